vga_axil_slave: RTL and testbench

VGA_AXIL_SLAVE -- requirements
Module: vga_axil_slave

---
 rtl/vga_axil_slave_if.sv | 36 +++
 rtl/vga_axil_slave.sv | 161 ++++++++++++++++
 tb/tb_vga_axil_slave.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_axil_slave_if.sv
// AXI4-Lite slave-side bus bundle for the VGA register port.
// The master modport is the bus initiator and the slave modport is the register block.
interface vga_axil_slave_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 13
);
   localparam int unsigned SW = DW / 8;

   logic          awvalid;
   logic          awready;
   logic [AW-1:0] awaddr;
   logic          wvalid;
   logic          wready;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          bvalid;
   logic          bready;
   logic [1:0]    bresp;
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave bridging CPU accesses to the VGA core's simple latched write/read port.
// Optional macro VGA_AXIL_ERR_RESP_EN enables address range checking with SLVERR responses.
module vga_axil_slave #(
   parameter int unsigned C_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_AXI_ADDR_WIDTH = 13,
   parameter int unsigned READ_LAT         = 4
) (
   input  logic                            clk_i,
   input  logic                            rstn_i,
   vga_axil_slave_if.slave                 s_axil,
   output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
   output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
   output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
   output logic                            axil_wready_o,
   output logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_o,
   output logic                            axil_rreq_o,
   input  logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_i
);
   localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

   w_state_t      w_state;
   r_state_t      r_state;
   logic          aw_hs, w_hs, ar_hs;
   logic          aw_done, w_done;
   logic          w_err, r_err, w_err_q;
   logic [CW-1:0] lat_cnt;

   always_comb begin
      aw_hs = s_axil.awvalid & s_axil.awready;
      w_hs  = s_axil.wvalid  & s_axil.wready;
      ar_hs = s_axil.arvalid & s_axil.arready;
   end

`ifdef VGA_AXIL_ERR_RESP_EN
   // The write address may arrive this cycle or may already sit in axil_waddr_o.
   logic [C_AXI_ADDR_WIDTH-1:0] w_addr_eff;
   always_comb begin
      w_addr_eff = aw_hs ? s_axil.awaddr : axil_waddr_o;
      w_err      = (32'(w_addr_eff) >= 32'd6496);
      r_err      = !s_axil.araddr[12] || (32'(s_axil.araddr) >= 32'd6496);
   end
`else
   always_comb begin
      w_err = 1'b0;
      r_err = 1'b0;
   end
`endif

   // Write path: collect AW and W in any order, strobe the core once, then respond.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         w_state        <= W_IDLE;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         w_err_q        <= 1'b0;
         s_axil.awready <= 1'b0;
         s_axil.wready  <= 1'b0;
         s_axil.bvalid  <= 1'b0;
         s_axil.bresp   <= 2'b00;
         axil_wready_o  <= 1'b0;
         axil_waddr_o   <= '0;
         axil_wdata_o   <= '0;
         axil_wstrb_o   <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) axil_waddr_o <= s_axil.awaddr;
               if (w_hs) begin
                  axil_wdata_o <= s_axil.wdata;
                  axil_wstrb_o <= s_axil.wstrb;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  w_state        <= W_ISSUE;
                  aw_done        <= 1'b0;
                  w_done         <= 1'b0;
                  s_axil.awready <= 1'b0;
                  s_axil.wready  <= 1'b0;
                  axil_wready_o  <= !w_err;
                  w_err_q        <= w_err;
               end else begin
                  aw_done        <= aw_done || aw_hs;
                  w_done         <= w_done  || w_hs;
                  s_axil.awready <= !(aw_done || aw_hs);
                  s_axil.wready  <= !(w_done  || w_hs);
               end
            end
            W_ISSUE: begin
               axil_wready_o <= 1'b0;
               s_axil.bvalid <= 1'b1;
               s_axil.bresp  <= w_err_q ? 2'b10 : 2'b00;
               w_state       <= W_RESP;
            end
            W_RESP: begin
               if (s_axil.bready) begin
                  s_axil.bvalid  <= 1'b0;
                  s_axil.awready <= 1'b1;
                  s_axil.wready  <= 1'b1;
                  w_state        <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read path: hold the request for READ_LAT cycles, then capture and present the data.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state        <= R_IDLE;
         lat_cnt        <= '0;
         s_axil.arready <= 1'b0;
         s_axil.rvalid  <= 1'b0;
         s_axil.rresp   <= 2'b00;
         s_axil.rdata   <= '0;
         axil_raddr_o   <= '0;
         axil_rreq_o    <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               s_axil.arready <= 1'b1;
               if (ar_hs) begin
                  s_axil.arready <= 1'b0;
                  axil_raddr_o   <= s_axil.araddr;
                  if (r_err) begin
                     s_axil.rvalid <= 1'b1;
                     s_axil.rresp  <= 2'b10;
                     s_axil.rdata  <= '0;
                     r_state       <= R_RESP;
                  end else begin
                     axil_rreq_o <= 1'b1;
                     lat_cnt     <= '0;
                     r_state     <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               if (lat_cnt == CW'(READ_LAT - 1)) begin
                  s_axil.rdata  <= axil_rdata_i;
                  s_axil.rresp  <= 2'b00;
                  s_axil.rvalid <= 1'b1;
                  axil_rreq_o   <= 1'b0;
                  r_state       <= R_RESP;
               end else begin
                  lat_cnt <= lat_cnt + CW'(1);
               end
            end
            R_RESP: begin
               if (s_axil.rready) begin
                  s_axil.rvalid  <= 1'b0;
                  s_axil.arready <= 1'b1;
                  r_state        <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_axil_slave.sv
// Directed bench for vga_axil_slave: write/read handshakes, latency, concurrency and reset.
// Covers address checking when VGA_AXIL_ERR_RESP_EN is defined.
module tb_vga_axil_slave;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 13;
`ifdef VGA_AXIL_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic [AW-1:0] axil_waddr_o;
   logic [DW-1:0] axil_wdata_o;
   logic [3:0]    axil_wstrb_o;
   logic          axil_wready_o;
   logic [AW-1:0] axil_raddr_o;
   logic          axil_rreq_o;
   logic [DW-1:0] axil_rdata_i;

   int checks = 0;
   int errors = 0;
   int wpulses = 0;
   int rreq_cycles = 0;

   always #10 clk_i = ~clk_i;

   vga_axil_slave_if #(.DW(DW), .AW(AW)) bus ();

   vga_axil_slave #(
      .C_AXI_DATA_WIDTH(DW),
      .C_AXI_ADDR_WIDTH(AW),
      .READ_LAT(4)
   ) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .s_axil        (bus),
      .axil_waddr_o  (axil_waddr_o),
      .axil_wdata_o  (axil_wdata_o),
      .axil_wstrb_o  (axil_wstrb_o),
      .axil_wready_o (axil_wready_o),
      .axil_raddr_o  (axil_raddr_o),
      .axil_rreq_o   (axil_rreq_o),
      .axil_rdata_i  (axil_rdata_i)
   );

   always @(negedge clk_i) begin
      if (axil_wready_o) wpulses++;
      if (axil_rreq_o) rreq_cycles++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int p0, r0, bt, rt, cnt;
      logic stable;
      logic [DW-1:0] rd;
      logic [1:0] rr;

      rstn_i = 1'b0;
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
      axil_rdata_i = '0;
      repeat (3) tick();
      check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
      check("rst_valid", {bus.bvalid, bus.rvalid, axil_wready_o, axil_rreq_o}, 4'b0000);
      check("rst_data", {axil_waddr_o, axil_wdata_o, bus.rdata, bus.bresp, bus.rresp}, '0);
      rstn_i = 1'b1;
      tick();
      check("idle_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // Same-cycle AW and W
      p0 = wpulses;
      bus.awvalid = 1'b1; bus.awaddr = 13'h1004;
      bus.wvalid = 1'b1; bus.wdata = 32'h41424344; bus.wstrb = 4'hF;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("w1_strobe", axil_wready_o, 1'b1);
      check("w1_beat", {axil_waddr_o, axil_wdata_o, axil_wstrb_o}, {13'h1004, 32'h41424344, 4'hF});
      check("w1_busy", {bus.awready, bus.wready, bus.bvalid}, 3'b000);
      tick();
      check("w1_b", {axil_wready_o, bus.bvalid, bus.bresp}, {1'b0, 1'b1, 2'b00});
      tick();
      check("w1_bhold", bus.bvalid, 1'b1);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("w1_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
      check("w1_pulses", wpulses - p0, 1);

      // W three cycles ahead of AW
      p0 = wpulses;
      bus.wvalid = 1'b1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'h3;
      tick();
      bus.wvalid = 1'b0;
      check("w2_wfirst", {bus.wready, bus.awready, axil_wready_o}, 3'b010);
      tick();
      tick();
      bus.awvalid = 1'b1; bus.awaddr = 13'h1000;
      tick();
      bus.awvalid = 1'b0;
      check("w2_beat", {axil_wready_o, axil_waddr_o, axil_wdata_o, axil_wstrb_o},
            {1'b1, 13'h1000, 32'hDEADBEEF, 4'h3});
      tick();
      check("w2_b", {bus.bvalid, bus.bresp}, 3'b100);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("w2_pulses", wpulses - p0, 1);
      check("w2_hold", {axil_waddr_o, axil_wdata_o}, {13'h1000, 32'hDEADBEEF});

      // Read latency and response hold
      r0 = rreq_cycles;
      axil_rdata_i = 32'h11223344;
      bus.arvalid = 1'b1; bus.araddr = 13'h1008;
      tick();
      bus.arvalid = 1'b0;
      check("r1_req", {axil_rreq_o, axil_raddr_o, bus.arready}, {1'b1, 13'h1008, 1'b0});
      for (int i = 0; i < 3; i++) begin
         tick();
         check("r1_wait", {bus.rvalid, axil_rreq_o}, 2'b01);
      end
      tick();
      check("r1_data", {bus.rvalid, axil_rreq_o, bus.rdata, bus.rresp},
            {1'b1, 1'b0, 32'h11223344, 2'b00});
      axil_rdata_i = 32'hFFFFFFFF;
      stable = 1'b1;
      repeat (10) begin
         tick();
         stable &= bus.rvalid && (bus.rdata == 32'h11223344) && (bus.rresp == 2'b00);
      end
      check("r1_stable", stable, 1'b1);
      check("r1_req_cycles", rreq_cycles - r0, 4);
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      check("r1_done", {bus.rvalid, bus.arready}, 2'b01);

      // Concurrent write and read
      axil_rdata_i = 32'hCAFEF00D;
      bus.bready = 1'b1; bus.rready = 1'b1;
      bus.awvalid = 1'b1; bus.awaddr = 13'h0800;
      bus.wvalid = 1'b1; bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF;
      bus.arvalid = 1'b1; bus.araddr = 13'h1000;
      bt = 0; rt = 0; rd = '0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
         if (bus.bvalid && bt == 0) bt = i;
         if (bus.rvalid && rt == 0) begin
            rt = i;
            rd = bus.rdata;
         end
      end
      bus.bready = 1'b0; bus.rready = 1'b0;
      check("c_b_lat", bt, 2);
      check("c_r_lat", rt, 5);
      check("c_rdata", rd, 32'hCAFEF00D);
      check("c_wbeat", {axil_waddr_o, axil_wdata_o}, {13'h0800, 32'h55AA55AA});

      // Reset while a read is waiting on the core
      bus.arvalid = 1'b1; bus.araddr = 13'h1010;
      tick();
      bus.arvalid = 1'b0;
      tick();
      check("rst_mid_req", axil_rreq_o, 1'b1);
      rstn_i = 1'b0;
      #1;
      check("rst_mid_out", {axil_rreq_o, bus.rvalid, bus.arready}, 3'b000);
      tick();
      rstn_i = 1'b1;
      tick();
      check("rst_mid_arready", bus.arready, 1'b1);
      stable = 1'b1;
      repeat (6) begin
         tick();
         stable &= !bus.rvalid && !axil_rreq_o && !bus.bvalid;
      end
      check("rst_mid_discard", stable, 1'b1);

      // Out-of-range write and low-half read
      p0 = wpulses;
      bus.awvalid = 1'b1; bus.awaddr = 13'h1960;
      bus.wvalid = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
      cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         bus.awvalid = 1'b0; bus.wvalid = 1'b0;
         if (bus.bvalid && cnt == 0) cnt = i;
      end
      check("e_b_seen", cnt, 2);
      check("e_bresp", bus.bresp, ERR_EN ? 2'b10 : 2'b00);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("e_pulses", wpulses - p0, ERR_EN ? 0 : 1);

      axil_rdata_i = 32'hA5A5A5A5;
      bus.arvalid = 1'b1; bus.araddr = 13'h0004;
      cnt = 0; rd = '1; rr = 2'b11;
      for (int i = 1; i <= 8; i++) begin
         tick();
         bus.arvalid = 1'b0;
         if (bus.rvalid && cnt == 0) begin
            cnt = i;
            rd = bus.rdata;
            rr = bus.rresp;
         end
      end
      check("e_r_lat", cnt, ERR_EN ? 1 : 5);
      check("e_rdata", rd, ERR_EN ? 32'h0 : 32'hA5A5A5A5);
      check("e_rresp", rr, ERR_EN ? 2'b10 : 2'b00);
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      check("e_r_done", {bus.rvalid, bus.arready}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
